// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, one bit per clock, LSB first.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   start  - request, sampled only while ready=1
//   a, b   - operands, captured on the accepting edge
//   cin    - carry-in, captured on the accepting edge
//   ready  - high in idle only
//   busy   - high while bits are being added
//   done   - one-cycle pulse after the last bit
//   sum    - registered result, held until the next accepted start
//   cout   - carry out of the MSB, held with sum
//   ovf    - two's-complement overflow, held with sum
module serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  // Holds the WIDTH-1 low result bits; the MSB arrives straight from the cell on the last edge.
  logic [WIDTH-2:0]   s_sr_q, s_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               prev_carry_q, prev_carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Full-adder cell: l is the sum bit, h the carry out.
  logic fa_a, fa_b, fa_c, fa_l, fa_h;
  assign fa_a = a_sr_q[0];
  assign fa_b = b_sr_q[0];
  assign fa_c = carry_q;
  assign fa_l = fa_a ^ fa_b ^ fa_c;
  assign fa_h = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  logic [WIDTH-1:0] s_shift;
  logic             last_bit;
  assign s_shift  = {fa_l, s_sr_q};
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    s_sr_d       = s_sr_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    prev_carry_d = prev_carry_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_shift[WIDTH-1:1];
        carry_d = fa_h;
        cnt_d   = cnt_q + CntW'(1);
        // Carry into the MSB, needed for signed overflow.
        if (cnt_q == CntW'(WIDTH - 2)) begin
          prev_carry_d = fa_h;
        end
        if (last_bit) begin
          cnt_d   = cnt_q;  // no wrap at WIDTH a power of two
          sum_d   = s_shift;
          cout_d  = fa_h;
          ovf_d   = prev_carry_q ^ fa_h;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      s_sr_q       <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      prev_carry_q <= 1'b0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      s_sr_q       <= s_sr_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      prev_carry_q <= prev_carry_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=16 and WIDTH=5.
module tb_serial_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        rst16, start16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        ready16, busy16, done16, cout16, ovf16;

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // WIDTH=5 instance
  logic        rst5, start5, cin5;
  logic [4:0]  a5, b5, sum5;
  logic        ready5, busy5, done5, cout5, ovf5;

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst5), .start(start5), .a(a5), .b(b5), .cin(cin5),
    .ready(ready5), .busy(busy5), .done(done5), .sum(sum5), .cout(cout5), .ovf(ovf5)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt16 = 0;

  always @(posedge clk) if (done16) done_cnt16++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the two's-complement and unsigned views.
  function automatic logic [64:0] ref_add(input int w, input longint unsigned x,
                                          input longint unsigned y, input bit c);
    longint unsigned t;
    t = x + y + longint'(c);
    return {1'b0, t} & ((65'd1 << (w + 1)) - 65'd1);
  endfunction

  function automatic bit ref_ovf(input int w, input longint unsigned x,
                                 input longint unsigned y, input bit c);
    longint sx, sy, t, lim;
    lim = longint'(1) << (w - 1);
    sx  = (x >= longint'(lim)) ? longint'(x) - 2 * lim : longint'(x);
    sy  = (y >= longint'(lim)) ? longint'(y) - 2 * lim : longint'(y);
    t   = sx + sy + longint'(c);
    return (t >= lim) || (t < -lim);
  endfunction

  // Runs one op on dut16 from idle; returns result sampled in the done cycle and the latency.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      input bit scramble, output logic [15:0] rs, output logic rc,
                      output logic ro, output int lat);
    @(negedge clk);
    chk("ready_before_start16", ready16, 1);
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("busy_after_accept16", {ready16, busy16, done16}, 3'b010);
    lat = 0;
    while (!done16 && lat < 40) begin
      if (scramble) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) chk("done_timeout16", 1, 0);
    rs = sum16; rc = cout16; ro = ovf16;
    @(negedge clk);
    chk("ready_after_done16", {ready16, busy16, done16}, 3'b100);
    chk("sum_held16", {cout16, ovf16, sum16}, {rc, ro, rs});
  endtask

  task automatic op5(input logic [4:0] ta, input logic [4:0] tb, input logic tc,
                     output logic [4:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clk);
    chk("ready_before_start5", ready5, 1);
    a5 = ta; b5 = tb; cin5 = tc; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    lat = 0;
    while (!done5 && lat < 20) begin
      a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) chk("done_timeout5", 1, 0);
    rs = sum5; rc = cout5; ro = ovf5;
    @(negedge clk);
    chk("ready_after_done5", ready5, 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;
    int          seen;
    logic [64:0] exp;
    logic [4:0]  rs5;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst16 = 1'b1; rst5 = 1'b1;
    start16 = 0; a16 = '0; b16 = '0; cin16 = 0;
    start5 = 0; a5 = '0; b5 = '0; cin5 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs16", {ready16, busy16, done16, cout16, ovf16, sum16}, {5'b10000, 16'h0});
    chk("reset_outputs5", {ready5, busy5, done5, cout5, ovf5, sum5}, {5'b10000, 5'h0});
    rst16 = 1'b0; rst5 = 1'b0;

    // Directed vectors
    foreach (vecs[i]) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
      chk($sformatf("vec%0d_result", i), {rc, ro, rs}, {vecs[i].cout, vecs[i].ovf, vecs[i].sum});
    end

    // Starts during RUN and DONE are ignored; start in the next idle cycle is accepted.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h0001; cin16 = 0; start16 = 1;
    @(negedge clk);
    start16 = 0;
    seen = done_cnt16;
    repeat (4) @(negedge clk);
    a16 = 16'h0001; b16 = 16'h0001; start16 = 1;
    @(negedge clk);
    start16 = 0;
    lat = 5;
    while (!done16 && lat < 40) begin @(negedge clk); lat++; end
    chk("ign_latency", 64'(lat), 64'd16);
    chk("ign_result", {cout16, ovf16, sum16}, {2'b00, 16'h0100});
    start16 = 1;  // during DONE: ignored
    @(negedge clk);
    chk("ign_idle_after_done", {ready16, busy16, done16}, 3'b100);
    chk("ign_single_done", 64'(done_cnt16 - seen), 64'd1);
    chk("ign_sum_held", sum16, 16'h0100);
    // start still high in this idle cycle: accepted at the next edge
    @(negedge clk);
    start16 = 0;
    chk("idle_start_accepted", busy16, 1);
    lat = 0;
    while (!done16 && lat < 40) begin @(negedge clk); lat++; end
    chk("idle_start_result", {cout16, ovf16, sum16}, {2'b00, 16'h0002});
    @(negedge clk);

    // Asynchronous reset in the 8th RUN cycle aborts the operation.
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; start16 = 1;
    @(negedge clk);
    start16 = 0;
    repeat (7) @(negedge clk);
    chk("busy_before_abort", busy16, 1);
    #2 rst16 = 1'b1;
    #1 chk("abort_outputs", {ready16, busy16, done16, cout16, sum16}, {4'b1000, 16'h0});
    @(negedge clk);
    rst16 = 1'b0;
    seen = done_cnt16;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt16 - seen), 64'd0);
    op16(16'h0003, 16'h0004, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("after_abort_result", {rc, ro, rs}, {2'b00, 16'h0007});

    // Random sweeps, operands scrambled during RUN.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rci;
      ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
      op16(ra, rb, rci, 1'b1, rs, rc, ro, lat);
      exp = ref_add(16, 64'(ra), 64'(rb), rci);
      chk("rand16_sum", {rc, rs}, exp[16:0]);
      chk("rand16_ovf", ro, ref_ovf(16, 64'(ra), 64'(rb), rci));
    end
    for (int i = 0; i < 1000; i++) begin
      logic [4:0] ra, rb;
      logic       rci;
      ra = 5'($urandom); rb = 5'($urandom); rci = 1'($urandom);
      op5(ra, rb, rci, rs5, rc, ro, lat);
      exp = ref_add(5, 64'(ra), 64'(rb), rci);
      chk("rand5_latency", 64'(lat), 64'd5);
      chk("rand5_sum", {rc, rs5}, exp[5:0]);
      chk("rand5_ovf", ro, ref_ovf(5, 64'(ra), 64'(rb), rci));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
